chime_sequencer: RTL and testbench

Sequences and arbitrates tone playback for the clock's single piezo buzzer. It accepts alarm and hourly-chime requests, grants the buzzer to one of them with alarm priority, and steps through a short melody read from a note ROM. For each note it drives the square-wave generator's period word `divnum` and a gate `tone_on`. The top level ties the wave generator's `rst_n` to `rst_n & tone_on`, so every note restarts the waveform with clean phase and the buzzer is silent whenever `tone_on` is low.

---
 rtl/chime_pkg.sv | 60 ++++++
 rtl/chime_note_rom.sv | 25 ++
 rtl/chime_sequencer.sv | 143 ++++++++++++++
 tb/tb_chime_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/chime_pkg.sv
// Shared types, encodings, note-entry layout and pitch arithmetic for the chime sequencer.
package chime_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  localparam logic [1:0] SRC_NONE  = 2'b00;
  localparam logic [1:0] SRC_CHIME = 2'b01;
  localparam logic [1:0] SRC_ALARM = 2'b10;

  localparam logic [4:0] ALARM_BASE = 5'd0;
  localparam logic [4:0] CHIME_BASE = 5'd16;

  // Note entry: [15] last, [14:11] pitch code (0 = rest), [10:0] duration in ms
  localparam int LAST_BIT = 15;
  localparam int CODE_HI  = 14;
  localparam int CODE_LO  = 11;
  localparam int DUR_HI   = 10;
  localparam int DUR_LO   = 0;

  // Pitch codes 1..15 walk the C major scale from C5 up to C7
  function automatic int unsigned freq_hz(input logic [3:0] code);
    case (code)
      4'd1:    return 523;
      4'd2:    return 587;
      4'd3:    return 659;
      4'd4:    return 698;
      4'd5:    return 784;
      4'd6:    return 880;
      4'd7:    return 988;
      4'd8:    return 1047;
      4'd9:    return 1175;
      4'd10:   return 1319;
      4'd11:   return 1397;
      4'd12:   return 1568;
      4'd13:   return 1760;
      4'd14:   return 1976;
      4'd15:   return 2093;
      default: return 0;
    endcase
  endfunction

  // Clock cycles per output period, rounded down; a rest maps to 0
  function automatic logic [31:0] pitch_div(input int unsigned clk_hz, input logic [3:0] code);
    if (code == 4'd0) return 32'd0;
    return 32'(clk_hz / freq_hz(code));
  endfunction

  // Whole code -> period table, evaluated once at elaboration
  function automatic logic [15:0][31:0] div_table(input int unsigned clk_hz);
    logic [15:0][31:0] t;
    for (int i = 0; i < 16; i++) t[i] = pitch_div(clk_hz, 4'(i));
    return t;
  endfunction

  function automatic logic [15:0] mk_note(input logic last, input logic [3:0] code,
                                          input logic [10:0] dur);
    return {last, code, dur};
  endfunction

endpackage

// File: rtl/chime_note_rom.sv
// Melody storage: alarm tune at 0..15, hourly chime at 16..31.
module chime_note_rom
  import chime_pkg::*;
(
  input  logic [4:0]  ptr,
  output logic [15:0] entry
);

  // Combinational lookup; unused slots read as a zero-length rest
  always_comb begin
    entry = '0;
    case (ptr)
      // alarm: A5 3 ms, rest 2 ms, C6 with zero length (plays as 1 ms)
      5'd0:    entry = mk_note(1'b0, 4'd6, 11'd3);
      5'd1:    entry = mk_note(1'b0, 4'd0, 11'd2);
      5'd2:    entry = mk_note(1'b1, 4'd8, 11'd0);
      // chime: E5 2 ms, G5 1 ms, C6 3 ms
      5'd16:   entry = mk_note(1'b0, 4'd3, 11'd2);
      5'd17:   entry = mk_note(1'b0, 4'd5, 11'd1);
      5'd18:   entry = mk_note(1'b1, 4'd8, 11'd3);
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/chime_sequencer.sv
// Buzzer owner: arbitrates alarm/chime requests and plays the note ROM melody.
module chime_sequencer
  import chime_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned GAP_MS        = 20,
  parameter int unsigned ALARM_REPEATS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alarm_req,
  input  logic        chime_req,
  input  logic        stop,
  output logic [31:0] divnum,
  output logic        tone_on,
  output logic        busy,
  output logic [1:0]  src
);

  localparam int unsigned TICK_DIV = CLK_HZ / 1000;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int REP_W = $clog2(ALARM_REPEATS + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(ALARM_REPEATS - 1);
  localparam logic [10:0] GAP_LEN = 11'(GAP_MS);
  localparam logic [15:0][31:0] PITCH_DIV = div_table(CLK_HZ);

  state_t           state;
  logic [4:0]       ptr;
  logic [REP_W-1:0] rep;
  logic [PRE_W-1:0] pre;
  logic [10:0]      ms_left;
  logic             alarm_pend, chime_pend;
  logic [15:0]      entry;
  logic             last;
  logic [3:0]       code;
  logic [10:0]      dur;
  logic             tick, ms_end;

  chime_note_rom u_rom (.ptr(ptr), .entry(entry));

  assign last   = entry[LAST_BIT];
  assign code   = entry[CODE_HI:CODE_LO];
  assign dur    = entry[DUR_HI:DUR_LO];
  assign tick   = (pre == PRE_MAX);
  assign ms_end = tick && (ms_left == 11'd1);

  // Request latching, arbitration, melody stepping and ms timing in one FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      rep        <= '0;
      pre        <= '0;
      ms_left    <= '0;
      alarm_pend <= 1'b0;
      chime_pend <= 1'b0;
      divnum     <= '0;
      tone_on    <= 1'b0;
      busy       <= 1'b0;
      src        <= SRC_NONE;
    end else begin
      // a source that already owns the buzzer ignores its own request
      if (alarm_req && src != SRC_ALARM) alarm_pend <= 1'b1;
      if (chime_req && src != SRC_CHIME) chime_pend <= 1'b1;

      if (stop) begin
        state      <= IDLE;
        alarm_pend <= 1'b0;
        chime_pend <= 1'b0;
        tone_on    <= 1'b0;
        busy       <= 1'b0;
        src        <= SRC_NONE;
      end else if (src == SRC_CHIME && (alarm_req || alarm_pend)) begin
        // alarm preempts a running chime; the chime is dropped for good
        state      <= LOAD;
        ptr        <= ALARM_BASE;
        rep        <= '0;
        src        <= SRC_ALARM;
        alarm_pend <= 1'b0;
        tone_on    <= 1'b0;
        busy       <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (alarm_pend) begin
              state      <= LOAD;
              ptr        <= ALARM_BASE;
              rep        <= '0;
              src        <= SRC_ALARM;
              busy       <= 1'b1;
              alarm_pend <= 1'b0;
            end else if (chime_pend) begin
              state      <= LOAD;
              ptr        <= CHIME_BASE;
              src        <= SRC_CHIME;
              busy       <= 1'b1;
              chime_pend <= 1'b0;
            end
          end
          LOAD: begin
            if (code != 4'd0) divnum <= PITCH_DIV[code];
            ms_left <= (dur == 11'd0) ? 11'd1 : dur;
            pre     <= '0;
            tone_on <= (code != 4'd0);
            state   <= PLAY;
          end
          PLAY: begin
            pre <= tick ? '0 : pre + 1'b1;
            if (ms_end) begin
              state   <= GAP;
              tone_on <= 1'b0;
              ms_left <= GAP_LEN;
            end else if (tick) begin
              ms_left <= ms_left - 11'd1;
            end
          end
          GAP: begin
            pre <= tick ? '0 : pre + 1'b1;
            if (ms_end) begin
              if (!last) begin
                ptr   <= ptr + 5'd1;
                state <= LOAD;
              end else if (src == SRC_ALARM && rep < REP_MAX) begin
                rep   <= rep + 1'b1;
                ptr   <= ALARM_BASE;
                state <= LOAD;
              end else begin
                state <= IDLE;
                src   <= SRC_NONE;
                busy  <= 1'b0;
              end
            end else if (tick) begin
              ms_left <= ms_left - 11'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chime_sequencer.sv
// Self-checking bench: hand-derived vector table plus a trace-queue reference model.
module tb_chime_sequencer;

  logic        clk;
  logic        rst_n;
  logic        alarm_req, chime_req, stop;
  logic [31:0] divnum;
  logic        tone_on, busy;
  logic [1:0]  src;

  int checks = 0;
  int errors = 0;

  chime_sequencer #(.CLK_HZ(10_000), .GAP_MS(2), .ALARM_REPEATS(2)) dut (
    .clk(clk), .rst_n(rst_n), .alarm_req(alarm_req), .chime_req(chime_req), .stop(stop),
    .divnum(divnum), .tone_on(tone_on), .busy(busy), .src(src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: each grant expands to a per-cycle trace ----------------
  typedef struct packed {
    logic        tone;
    logic        busy;
    logic [1:0]  src;
    logic [31:0] div;
  } out_t;

  int freq [16] = '{0, 523, 587, 659, 698, 784, 880, 988, 1047, 1175, 1319, 1397, 1568, 1760, 1976, 2093};
  int al_code [3] = '{6, 0, 8};
  int al_dur  [3] = '{3, 2, 0};
  int ch_code [3] = '{3, 5, 8};
  int ch_dur  [3] = '{2, 1, 3};

  out_t q[$];
  out_t exp_o = '0;
  out_t prev, idle_o, got;
  bit   pa = 0, pc = 0, na, nc;

  // 10 cycles per ms, 20-cycle gap, alarm played twice
  task automatic build(input bit alarm, input logic [31:0] d0);
    logic [31:0] cur;
    logic [1:0]  s;
    int passes, c, d;
    cur = d0;
    s = alarm ? 2'b10 : 2'b01;
    passes = alarm ? 2 : 1;
    for (int p = 0; p < passes; p++) begin
      for (int n = 0; n < 3; n++) begin
        c = alarm ? al_code[n] : ch_code[n];
        d = alarm ? al_dur[n] : ch_dur[n];
        if (d == 0) d = 1;
        q.push_back({1'b0, 1'b1, s, cur});
        if (c != 0) cur = 32'(10_000 / freq[c]);
        for (int i = 0; i < d * 10; i++) q.push_back({(c != 0), 1'b1, s, cur});
        for (int i = 0; i < 20; i++) q.push_back({1'b0, 1'b1, s, cur});
      end
    end
  endtask

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        pa = 0;
        pc = 0;
        exp_o = '0;
      end else begin
        prev = exp_o;
        idle_o = prev;
        idle_o.tone = 1'b0;
        idle_o.busy = 1'b0;
        idle_o.src = 2'b00;
        na = pa | (alarm_req && prev.src != 2'b10);
        nc = pc | (chime_req && prev.src != 2'b01);
        if (stop) begin
          q.delete();
          na = 0;
          nc = 0;
          exp_o = idle_o;
        end else if (prev.src == 2'b01 && (alarm_req || pa)) begin
          q.delete();
          build(1'b1, prev.div);
          na = 0;
          exp_o = q.pop_front();
        end else if (q.size() > 0) begin
          exp_o = q.pop_front();
        end else if (prev.busy) begin
          exp_o = idle_o;
        end else if (pa) begin
          build(1'b1, prev.div);
          na = 0;
          exp_o = q.pop_front();
        end else if (pc) begin
          build(1'b0, prev.div);
          nc = 0;
          exp_o = q.pop_front();
        end else begin
          exp_o = idle_o;
        end
        pa = na;
        pc = nc;
      end
    end
  end

  // every cycle, away from the rising edge, the DUT must match the model trace
  initial begin : monitor
    forever begin
      @(negedge clk);
      got = {tone_on, busy, src, divnum};
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL model t=%0t got tone=%b busy=%b src=%b div=%0d want tone=%b busy=%b src=%b div=%0d",
                 $time, tone_on, busy, src, divnum, exp_o.tone, exp_o.busy, exp_o.src, exp_o.div);
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          a, c, s;
    int          k;
    bit          tone, bsy;
    logic [1:0]  sr;
    logic [31:0] div;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit a, bit c, bit s, int k, bit t, bit b, logic [1:0] sr, int dv);
    vec_t v;
    v.a = a; v.c = c; v.s = s; v.k = k; v.tone = t; v.bsy = b; v.sr = sr; v.div = 32'(dv);
    return v;
  endfunction

  task automatic check_out(input string name, input bit t, input bit b, input logic [1:0] sr,
                           input logic [31:0] dv);
    checks++;
    if (tone_on !== t || busy !== b || src !== sr || divnum !== dv) begin
      errors++;
      $display("FAIL %s got tone=%b busy=%b src=%b div=%0d want tone=%b busy=%b src=%b div=%0d",
               name, tone_on, busy, src, divnum, t, b, sr, dv);
    end
  endtask

  initial begin : stim
    rst_n = 1'b0;
    alarm_req = 1'b0;
    chime_req = 1'b0;
    stop = 1'b0;

    //        a  c  s   k  tone busy src    div
    vt.push_back(mk(0, 1, 0,   0, 0, 0, 2'b00,  0));  // chime pulse: still IDLE
    vt.push_back(mk(0, 0, 0,   0, 0, 1, 2'b01,  0));  // LOAD
    vt.push_back(mk(0, 0, 0,   0, 1, 1, 2'b01, 15));  // E5 playing
    vt.push_back(mk(0, 0, 0,  18, 1, 1, 2'b01, 15));  // last E5 cycle
    vt.push_back(mk(0, 0, 0,   0, 0, 1, 2'b01, 15));  // gap
    vt.push_back(mk(0, 0, 0,  19, 0, 1, 2'b01, 15));  // LOAD G5
    vt.push_back(mk(0, 0, 0,   0, 1, 1, 2'b01, 12));  // G5
    vt.push_back(mk(0, 0, 0,   9, 0, 1, 2'b01, 12));  // gap after 10 cycles
    vt.push_back(mk(0, 0, 0,  69, 0, 1, 2'b01,  9));  // final gap cycle
    vt.push_back(mk(0, 0, 0,   0, 0, 0, 2'b00,  9));  // IDLE
    vt.push_back(mk(1, 1, 0,   1, 0, 1, 2'b10,  9));  // both: alarm wins, LOAD
    vt.push_back(mk(0, 0, 0,   0, 1, 1, 2'b10, 11));  // A5
    vt.push_back(mk(0, 0, 0,  28, 1, 1, 2'b10, 11));  // A5 last cycle
    vt.push_back(mk(0, 0, 0,   0, 0, 1, 2'b10, 11));  // gap
    vt.push_back(mk(0, 0, 0,  20, 0, 1, 2'b10, 11));  // rest: silent, div held
    vt.push_back(mk(0, 0, 0,  19, 0, 1, 2'b10, 11));  // gap after rest
    vt.push_back(mk(0, 0, 0,  20, 1, 1, 2'b10,  9));  // zero-length C6
    vt.push_back(mk(0, 0, 0,   9, 0, 1, 2'b10,  9));  // gap after 10 cycles
    vt.push_back(mk(0, 0, 0,  19, 0, 1, 2'b10,  9));  // second pass LOAD
    vt.push_back(mk(0, 0, 0,   0, 1, 1, 2'b10, 11));  // second pass A5
    vt.push_back(mk(0, 0, 0, 121, 0, 0, 2'b00,  9));  // alarm done: IDLE
    vt.push_back(mk(0, 0, 0,   0, 0, 1, 2'b01,  9));  // pending chime LOAD
    vt.push_back(mk(0, 0, 0,   0, 1, 1, 2'b01, 15));  // chime E5
    vt.push_back(mk(0, 0, 0,   5, 1, 1, 2'b01, 15));  // mid-note
    vt.push_back(mk(1, 0, 0,   0, 0, 1, 2'b10, 15));  // preempt: LOAD for alarm
    vt.push_back(mk(0, 0, 0,   0, 1, 1, 2'b10, 11));  // alarm A5
    vt.push_back(mk(0, 0, 0, 244, 0, 0, 2'b00,  9));  // alarm done
    vt.push_back(mk(0, 0, 0,   3, 0, 0, 2'b00,  9));  // chime not replayed
    vt.push_back(mk(1, 0, 0,   2, 1, 1, 2'b10, 11));  // alarm playing
    vt.push_back(mk(0, 1, 0,   2, 1, 1, 2'b10, 11));  // chime goes pending
    vt.push_back(mk(0, 0, 1,   0, 0, 0, 2'b00, 11));  // stop: silent, div held
    vt.push_back(mk(0, 0, 0,  10, 0, 0, 2'b00, 11));  // pending chime dropped
    vt.push_back(mk(0, 1, 1,   3, 0, 0, 2'b00, 11));  // stop beats request

    repeat (3) @(negedge clk);
    check_out("reset", 1'b0, 1'b0, 2'b00, 32'd0);
    rst_n = 1'b1;

    for (int r = 0; r < vt.size(); r++) begin
      alarm_req = vt[r].a;
      chime_req = vt[r].c;
      stop      = vt[r].s;
      @(negedge clk);
      alarm_req = 1'b0;
      chime_req = 1'b0;
      stop      = 1'b0;
      repeat (vt[r].k) @(negedge clk);
      check_out($sformatf("row%0d", r), vt[r].tone, vt[r].bsy, vt[r].sr, vt[r].div);
    end

    // asynchronous reset in the middle of a note
    alarm_req = 1'b1;
    @(negedge clk);
    alarm_req = 1'b0;
    repeat (5) @(negedge clk);
    check_out("pre_rst_play", 1'b1, 1'b1, 2'b10, 32'd11);
    #2 rst_n = 1'b0;
    #1 check_out("async_rst", 1'b0, 1'b0, 2'b00, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic, checked cycle by cycle by the model
    for (int i = 0; i < 6000; i++) begin
      alarm_req = ($urandom_range(0, 299) == 0);
      chime_req = ($urandom_range(0, 149) == 0);
      stop      = ($urandom_range(0, 699) == 0);
      @(negedge clk);
    end
    alarm_req = 1'b0;
    chime_req = 1'b0;
    stop = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
